// File: rtl/posit_decode.sv
// Two-stage posit field decoder: stage 1 captures sign, magnitude and special flags,
// stage 2 splits regime/exponent/fraction. Define POSIT_DECODE_STATS_EN for counters.
module posit_decode #(
    parameter int N  = 10,
    parameter int ES = 4,
    parameter int RS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_posit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [RS+ES-1:0]   out_scale,
    output logic [N-1-RS-ES:0] out_frac,
    output logic               out_pzero,
    output logic               out_pinf
`ifdef POSIT_DECODE_STATS_EN
    ,
    output logic [15:0]        word_cnt,
    output logic [15:0]        special_cnt
`endif
);
    localparam int FW = N - 1 - RS - ES;
    localparam int SW = RS + ES;
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    // valid/ready: a transfer happens on any rising edge where valid && ready;
    // a producer holds its data stable while valid && !ready.
    logic          s1_valid_q, s1_valid_d;
    logic          sign_q, sign_d;
    logic [N-2:0]  mag_q, mag_d;
    logic          zero_q, zero_d;
    logic          nar_q, nar_d;

    logic          out_valid_q, out_valid_d;
    logic          out_sign_q, out_sign_d;
    logic [SW-1:0] out_scale_q, out_scale_d;
    logic [FW:0]   out_frac_q, out_frac_d;
    logic          out_pzero_q, out_pzero_d;
    logic          out_pinf_q, out_pinf_d;

    logic s2_adv, s1_adv, accept;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = reset && (!s1_valid_q || s2_adv);
    assign accept   = in_valid && in_ready;

    logic [N-1:0] full_mag;

    always_comb begin
        s1_valid_d = s1_valid_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        zero_d     = zero_q;
        nar_d      = nar_q;
        full_mag   = in_posit[N-1] ? -in_posit : in_posit;
        if (in_ready) s1_valid_d = in_valid;
        if (accept) begin
            sign_d = in_posit[N-1];
            mag_d  = full_mag[N-2:0];
            zero_d = (in_posit == '0);
            nar_d  = (in_posit == NAR);
        end
    end

    logic [RS-1:0] reg_bits;
    logic [ES-1:0] exp_bits;
    logic [FW-1:0] frac_bits;
    logic [SW-1:0] dec_scale;
    int            run;
    int            k;
    logic          stop;

    // Regime is a bounded run: it ends at the first opposite bit or at the field edge.
    always_comb begin
        reg_bits  = mag_q[N-2 -: RS];
        exp_bits  = mag_q[N-2-RS -: ES];
        frac_bits = mag_q[FW-1:0];
        run       = 0;
        stop      = 1'b0;
        for (int i = RS - 1; i >= 0; i--) begin
            if (!stop && (reg_bits[i] == reg_bits[RS-1])) run = run + 1;
            else stop = 1'b1;
        end
        k         = reg_bits[RS-1] ? (run - 1) : -run;
        dec_scale = SW'(k * (1 << ES) + int'(exp_bits));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_scale_d = out_scale_q;
        out_frac_d  = out_frac_q;
        out_pzero_d = out_pzero_q;
        out_pinf_d  = out_pinf_q;
        if (s2_adv) out_valid_d = s1_valid_q;
        if (s1_adv) begin
            if (zero_q || nar_q) begin
                out_sign_d  = 1'b0;
                out_scale_d = '0;
                out_frac_d  = '0;
                out_pzero_d = zero_q;
                out_pinf_d  = nar_q;
            end else begin
                out_sign_d  = sign_q;
                out_scale_d = dec_scale;
                out_frac_d  = {1'b1, frac_bits};
                out_pzero_d = 1'b0;
                out_pinf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            zero_q      <= 1'b0;
            nar_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_scale_q <= '0;
            out_frac_q  <= '0;
            out_pzero_q <= 1'b0;
            out_pinf_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            zero_q      <= zero_d;
            nar_q       <= nar_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_scale_q <= out_scale_d;
            out_frac_q  <= out_frac_d;
            out_pzero_q <= out_pzero_d;
            out_pinf_q  <= out_pinf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_scale = out_scale_q;
    assign out_frac  = out_frac_q;
    assign out_pzero = out_pzero_q;
    assign out_pinf  = out_pinf_q;

`ifdef POSIT_DECODE_STATS_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] special_cnt_q, special_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        word_cnt_d    = word_cnt_q;
        special_cnt_d = special_cnt_q;
        if (out_valid_q && out_ready) begin
            if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
            if ((out_pzero_q || out_pinf_q) && (special_cnt_q != 16'hFFFF))
                special_cnt_d = special_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_cnt_q    <= '0;
            special_cnt_q <= '0;
        end else begin
            word_cnt_q    <= word_cnt_d;
            special_cnt_q <= special_cnt_d;
        end
    end

    assign word_cnt    = word_cnt_q;
    assign special_cnt = special_cnt_q;
`endif

endmodule

// File: tb/tb_posit_decode.sv
// Directed bench for posit_decode at default parameters: hand-computed decode table,
// latency, throughput, backpressure, mid-stream reset and (stats build) counters.
module tb_posit_decode;
    localparam int N  = 10;
    localparam int ES = 4;
    localparam int RS = 2;
    localparam int FW = N - 1 - RS - ES;
    localparam int SW = RS + ES;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  in_posit  = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_sign;
    logic [SW-1:0] out_scale;
    logic [FW:0]   out_frac;
    logic          out_pzero;
    logic          out_pinf;
`ifdef POSIT_DECODE_STATS_EN
    logic [15:0]   word_cnt;
    logic [15:0]   special_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [12:0] exp_q[$];
    bit acc;

    always #5 clk = ~clk;

    posit_decode dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_posit   (in_posit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_scale  (out_scale),
        .out_frac   (out_frac),
        .out_pzero  (out_pzero),
        .out_pinf   (out_pinf)
`ifdef POSIT_DECODE_STATS_EN
        ,
        .word_cnt   (word_cnt),
        .special_cnt(special_cnt)
`endif
    );

    // Packed as {pzero, pinf, sign, scale[5:0], frac[3:0]}.
    function automatic logic [12:0] expect_of(input logic [9:0] p);
        case (p)
            10'h100: return {2'b00, 1'b0, 6'd0,  4'd8};
            10'h19D: return {2'b00, 1'b0, 6'd19, 4'd13};
            10'h07F: return {2'b00, 1'b0, 6'd47, 4'd15};
            10'h0C5: return {2'b00, 1'b0, 6'd56, 4'd13};
            10'h1FF: return {2'b00, 1'b0, 6'd31, 4'd15};
            10'h300: return {2'b00, 1'b1, 6'd0,  4'd8};
            10'h3FF: return {2'b00, 1'b1, 6'd32, 4'd9};
            10'h201: return {2'b00, 1'b1, 6'd31, 4'd15};
            10'h000: return {2'b10, 1'b0, 6'd0,  4'd0};
            10'h200: return {2'b01, 1'b0, 6'd0,  4'd0};
            default: return 13'h1FFF;
        endcase
    endfunction

    function automatic logic [12:0] observed();
        return {out_pzero, out_pinf, out_sign, out_scale, out_frac};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scores the handshakes of the coming edge, then advances to the next falling edge.
    task automatic tick(output bit accepted);
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("emit_has_pending", 16'(exp_q.size()), 16'd1);
            else check("emit_fields", 16'(observed()), 16'(exp_q.pop_front()));
        end
        if (accepted) exp_q.push_back(expect_of(in_posit));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    logic [9:0]  singles [10] = '{10'h100, 10'h19D, 10'h07F, 10'h0C5, 10'h1FF,
                                  10'h300, 10'h3FF, 10'h201, 10'h000, 10'h200};
    logic [9:0]  stream  [6]  = '{10'h19D, 10'h300, 10'h000, 10'h07F, 10'h201, 10'h200};
    logic [7:0]  ov_hist;
    logic [12:0] snap;
    int          idx;
    int          t;
    int          emits;
    int          cyc;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 16'(in_ready), 16'd0);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_fields", 16'(observed()), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);

        // Single words: latency 2, decode table, fields held afterwards
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_posit = singles[i];
            tick(acc);
            check("single_accept", 16'(acc), 16'd1);
            in_valid = 1'b0;
            check("lat_cycle1_valid", 16'(out_valid), 16'd0);
            tick(acc);
            check("lat_cycle2_valid", 16'(out_valid), 16'd1);
            tick(acc);
            check("idle_valid", 16'(out_valid), 16'd0);
            check("idle_fields_held", 16'(observed()), 16'(expect_of(singles[i])));
        end
`ifdef POSIT_DECODE_STATS_EN
        check("word_cnt_singles", word_cnt, 16'd10);
        check("special_cnt_singles", special_cnt, 16'd2);
`endif

        // Four back-to-back words with out_ready held high
        ov_hist = '0;
        for (int j = 0; j < 8; j++) begin
            in_valid = (j < 4);
            if (j < 4) in_posit = stream[j];
            tick(acc);
            ov_hist[j] = out_valid;
        end
        check("b2b_valid_pattern", 16'(ov_hist), 16'h001E);
        check("b2b_queue_empty", 16'(exp_q.size()), 16'd0);

        // Backpressure: out_ready low for three cycles mid-stream
        idx  = 0;
        t    = 0;
        snap = '0;
        while ((idx < 6 || exp_q.size() != 0) && t < 40) begin
            in_valid = (idx < 6);
            if (idx < 6) in_posit = stream[idx];
            out_ready = !(t >= 3 && t < 6);
            #1;
            if (t == 3) snap = observed();
            if (t >= 3 && t < 6) begin
                check("stall_valid", 16'(out_valid), 16'd1);
                check("stall_in_ready", 16'(in_ready), 16'd0);
                check("stall_fields_hold", 16'(observed()), 16'(snap));
            end
            tick(acc);
            if (acc) idx++;
            t++;
        end
        check("bp_drained_in_budget", 16'(t < 40), 16'd1);
        check("bp_all_accepted", 16'(idx), 16'd6);
        check("bp_queue_empty", 16'(exp_q.size()), 16'd0);
        out_ready = 1'b1;

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_posit  = stream[0];
        tick(acc);
        in_posit  = stream[1];
        tick(acc);
        in_valid  = 1'b0;
        check("inflight_valid", 16'(out_valid), 16'd1);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 16'(in_ready), 16'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 16'(out_valid), 16'd0);
        check("midrst_fields", 16'(observed()), 16'd0);
`ifdef POSIT_DECODE_STATS_EN
        check("midrst_word_cnt", word_cnt, 16'd0);
        check("midrst_special_cnt", special_cnt, 16'd0);
`endif
        exp_q.delete();
        reset     = 1'b1;
        out_ready = 1'b1;
        ov_hist   = '0;
        for (int j = 0; j < 6; j++) begin
            tick(acc);
            ov_hist[j] = out_valid;
        end
        check("post_reset_no_emit", 16'(ov_hist), 16'd0);

`ifdef POSIT_DECODE_STATS_EN
        // Counter saturation after 65537 handshakes
        in_valid  = 1'b1;
        in_posit  = 10'h100;
        out_ready = 1'b1;
        emits     = 0;
        cyc       = 0;
        while (emits < 65537 && cyc < 70000) begin
            #1;
            if (out_valid && out_ready) emits++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("sat_emits_in_budget", 16'(cyc < 70000), 16'd1);
        check("sat_word_cnt", word_cnt, 16'hFFFF);
        check("sat_special_cnt", special_cnt, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/posit_decode.md
POSIT_DECODE -- requirements
Module: posit_decode

Interface
REQ-001 SHALL have parameter N, default 10, total posit word width in bits.
REQ-002 SHALL have parameter ES, default 4, exponent field width in bits.
REQ-003 SHALL have parameter RS, default 2, fixed (bounded) regime field width in bits; fraction width is FW = N-1-RS-ES (3 at defaults).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_posit holds a word to decode.
REQ-007 SHALL have port in_ready  output  1  block accepts in_posit this cycle.
REQ-008 SHALL have port in_posit  input  N  encoded posit word.
REQ-009 SHALL have port out_valid  output  1  decoded fields valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts decoded fields this cycle.
REQ-011 SHALL have port out_sign  output  1  sign of decoded value.
REQ-012 SHALL have port out_scale  output  RS+ES  signed scale, k*2^ES + e.
REQ-013 SHALL have port out_frac  output  FW+1  significand with hidden bit as MSB.
REQ-014 SHALL have ports out_pzero and out_pinf  output  1 each  word was zero / was NaR (1 followed by N-1 zeros).
REQ-015 SHALL have ports word_cnt and special_cnt  output  16 each  statistics counters (present only per REQ-031).

Function
REQ-016 SHALL accept a word on cycle where in_valid && in_ready; SHALL emit on cycle where out_valid && out_ready.
REQ-017 SHALL be a two-stage pipeline: stage 1 registers sign, two's-complement magnitude (if sign=1) and special flags; stage 2 registers decoded fields; latency 2 cycles from accept to out_valid with no backpressure.
REQ-018 SHALL sustain one word per cycle when out_ready is held 1.
REQ-019 SHALL stall stage 2 when out_valid && !out_ready, holding all out_* stable; stage 1 advances only when stage 2 is empty or emitting; in_ready = stage 1 empty or advancing (combinational on out_ready allowed).
REQ-020 SHALL decode regime from the RS bits after the sign (on magnitude): run of identical leading bits terminated by the opposite bit or by field end; leading 1s run r gives k=r-1, leading 0s run r gives k=-r (RS=2: 10->0, 11->1, 01->-1, 00->-2).
REQ-021 SHALL take next ES bits as unsigned exponent e and final FW bits as fraction f; out_scale = k*2^ES + e (range -32..31 at defaults); out_frac = {1,f}.
REQ-022 SHALL for in_posit == 0 assert out_pzero with out_sign=0, out_scale=0, out_frac=0.
REQ-023 SHALL for in_posit == {1,(N-1){0}} assert out_pinf with out_sign=0, out_scale=0, out_frac=0.
REQ-024 SHALL never assert out_pzero and out_pinf together; both 0 for ordinary words.
REQ-025 SHALL hold out_* fields at last emitted values while out_valid=0 (no X propagation).

Reset
REQ-026 SHALL, when reset=0 at a rising clk edge, clear both stage valid bits, drive out_valid=0, out_sign=0, out_scale=0, out_frac=0, out_pzero=0, out_pinf=0, word_cnt=0, special_cnt=0.
REQ-027 SHALL drive in_ready=0 while reset=0 and in_ready=1 on the first cycle after reset release.
REQ-028 SHALL discard words in flight when reset asserts mid-operation; no output handshake for them occurs after release.

Configuration
REQ-029 SHALL use macro POSIT_DECODE_STATS_EN to include statistics logic.
REQ-030 SHALL, with macro defined, increment word_cnt on each output handshake and special_cnt on each output handshake with out_pzero or out_pinf; both saturate at 16'hFFFF.
REQ-031 SHALL, without macro, omit word_cnt and special_cnt ports and counter logic entirely; decode behaviour identical.

Verification
REQ-032 SHALL cover ordinary words (defaults): 0x100 -> sign 0, scale 0, frac 8; 0x19D -> sign 0, scale 19, frac 13; 0x07F -> sign 0, scale -17, frac 15.
REQ-033 SHALL cover negatives: 0x300 -> sign 1, scale 0, frac 8, flags 0.
REQ-034 SHALL cover specials: 0x000 -> out_pzero=1, fields 0; 0x200 -> out_pinf=1, fields 0; with stats, special_cnt=2 after both emitted.
REQ-035 SHALL cover throughput and backpressure: 4 back-to-back words, out_ready=1 -> out_valid first 2 cycles after first accept, then 4 consecutive cycles; hold out_ready=0 for 3 cycles mid-stream -> outputs stable, in_ready=0 once both stages full, no loss or duplication, order preserved.
REQ-036 SHALL cover reset mid-stream: reset=0 with 2 words in flight -> next edge out_valid=0, counters 0; after release no stale word emitted.
REQ-037 SHALL cover counter saturation (stats build): 65537 handshakes -> word_cnt=16'hFFFF.
